instruction_fetch_unit: RTL

- Fetch stage of the processor: owns the program counter and drives `Address` into the combinational instruction memory.
- Captures the returned `Instruction` into the IF/ID pipeline register and handles hazard stalls and branch redirects.
- Detects fetches beyond the populated memory range and reports them as a sticky fault.
- Also keeps fetch and stall performance counters.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_perf_counter.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// 32-bit wrapping event counter with enable; RESET_VAL lets a bench start it near the wrap point.
module fetch_perf_counter #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Count enabled cycles, modulo 2^32
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RESET_VAL;
    end else if (en_i) begin
      count_q <= count_q + 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/FAULT control, IF/ID register and performance counters.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int unsigned MEM_WORDS        = 8192,
  parameter logic [31:0] FETCH_COUNT_INIT = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCPlus4,
  output logic        IF_Valid,
  output logic        FetchFault,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  localparam logic [31:0] MemWordsW = 32'(MEM_WORDS);

  fetch_state_e      state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   if_instr_q;
  logic [XLEN-1:0]   if_pc_q;
  logic [XLEN-1:0]   if_pc_plus4_q;
  logic              if_valid_q;
  logic              fault_q;

  logic [XLEN-1:0]   pc_plus4_s;
  logic              out_of_range_s;
  logic              fetch_en_s;
  logic              stall_en_s;

  // Full word index is compared so upper address bits can never alias into memory
  assign pc_plus4_s     = pc_q + 32'd4;
  assign out_of_range_s = ({2'b00, pc_q[31:2]} >= MemWordsW);

  // Counter enables follow the RUN-state priority: branch, then stall, then range check
  always_comb begin
    fetch_en_s = 1'b0;
    stall_en_s = 1'b0;
    if (state_q == RUN) begin
      if (BranchTaken) begin
        fetch_en_s = 1'b0;
        stall_en_s = 1'b0;
      end else if (Stall) begin
        stall_en_s = 1'b1;
      end else if (!out_of_range_s) begin
        fetch_en_s = 1'b1;
      end else begin
        fetch_en_s = 1'b0;
      end
    end else begin
      fetch_en_s = 1'b0;
      stall_en_s = 1'b0;
    end
  end

  // Fetch FSM with PC and IF/ID register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= BOOT;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= 32'h0000_0000;
      if_pc_plus4_q <= 32'h0000_0000;
      if_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
        end
        RUN: begin
          if (BranchTaken) begin
            pc_q          <= {BranchTarget[31:2], 2'b00};
            if_instr_q    <= NOP_INSTR;
            if_pc_q       <= 32'h0000_0000;
            if_pc_plus4_q <= 32'h0000_0000;
            if_valid_q    <= 1'b0;
          end else if (Stall) begin
            pc_q <= pc_q;
          end else if (out_of_range_s) begin
            state_q    <= FAULT;
            fault_q    <= 1'b1;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
          end else begin
            if_instr_q    <= Instruction;
            if_pc_q       <= pc_q;
            if_pc_plus4_q <= pc_plus4_s;
            if_valid_q    <= 1'b1;
            pc_q          <= pc_plus4_s;
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          // A corrupted state encoding is treated as a fault rather than silently resuming
          state_q    <= FAULT;
          fault_q    <= 1'b1;
          if_valid_q <= 1'b0;
          if_instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

  fetch_perf_counter #(
    .RESET_VAL(FETCH_COUNT_INIT)
  ) u_fetch_count (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .en_i   (fetch_en_s),
    .count_o(FetchCount)
  );

  fetch_perf_counter #(
    .RESET_VAL(32'h0000_0000)
  ) u_stall_count (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .en_i   (stall_en_s),
    .count_o(StallCount)
  );

  assign Address        = pc_q;
  assign IF_Instruction = if_instr_q;
  assign IF_PC          = if_pc_q;
  assign IF_PCPlus4     = if_pc_plus4_q;
  assign IF_Valid       = if_valid_q;
  assign FetchFault     = fault_q;

endmodule
